// File: rtl/yoda_pkg.sv
// yoda_pkg: capture/filter shared sample width and capture FSM states
package yoda_pkg;
   localparam int ADC_W = 8;
   typedef enum logic [1:0] {IDLE, CAPTURE, READOUT} cap_state_t;
endpackage

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port RAM, one write port, one registered read port
module capture_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 1024
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] wa,
   input  logic [DATA_W-1:0]        wd,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] ra,
   output logic [DATA_W-1:0]        rd
);
   logic [DATA_W-1:0] mem [DEPTH];
   // write port and registered read port; read data holds while re is low
   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
      if (re) rd <= mem[ra];
   end
endmodule

// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer: captures a LEN-sample ADC frame into RAM, then streams it out
module adc_capture_buffer
   import yoda_pkg::*;
#(
   parameter int DATA_W = ADC_W,
   parameter int DEPTH  = 1024,
   parameter int LEN    = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              adc_valid,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              busy,
   output logic              done,
   output logic [15:0]       dropped
);
   localparam int AW = $clog2(DEPTH);
   cap_state_t state;
   logic [AW-1:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [DATA_W-1:0] q;
   logic we, re, hs;
   assign we = state == CAPTURE && adc_valid;
   assign re = state == READOUT && (!m_valid || m_ready) && rd_ptr < (AW+1)'(LEN);
   assign hs = m_valid && m_ready;
   assign m_last = m_valid && rd_ptr == (AW+1)'(LEN);
   assign m_data = m_valid ? q : '0;
   assign busy = state != IDLE;
   capture_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) ram (
      .clk(clk),
      .we(we),
      .wa(wr_ptr),
      .wd(adc_data),
      .re(re),
      .ra(rd_ptr[AW-1:0]),
      .rd(q)
   );
   // frame FSM with write/read pointers; rd_ptr has one extra bit to reach LEN == DEPTH
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (state == IDLE && start) begin
            state  <= CAPTURE;
            wr_ptr <= '0;
         end
         if (we) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == AW'(LEN - 1)) begin
               state  <= READOUT;
               rd_ptr <= '0;
            end
         end
         if (re) rd_ptr <= rd_ptr + 1'b1;
         if (hs && m_last) state <= IDLE;
      end
   end
   // output valid follows each RAM read and clears on a handshake with nothing prefetched
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         done    <= 1'b0;
      end else begin
         m_valid <= re ? 1'b1 : (m_ready ? 1'b0 : m_valid);
         done    <= hs && m_last;
      end
   end
   // saturating count of ADC samples that arrive while not capturing
   always_ff @(posedge clk) begin
      if (rst) dropped <= '0;
      else if (adc_valid && state != CAPTURE && dropped != 16'hFFFF) dropped <= dropped + 1'b1;
   end
endmodule

// File: tb/tb_adc_capture_buffer.sv
// tb_adc_capture_buffer: scoreboard bench driving three frame lengths (8, 16 = DEPTH, 1)
module tb_adc_capture_buffer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic adc_valid = 1'b0;
   logic m_ready = 1'b0;
   logic [7:0] adc_data = 8'h00;
   logic [7:0] m_data [3];
   logic m_valid [3];
   logic m_last [3];
   logic busy [3];
   logic done [3];
   logic [15:0] dropped [3];
   int tests = 0;
   int fails = 0;
   int lens [3] = '{8, 16, 1};
   int st [3] = '{default: 0};
   int age [3] = '{default: 0};
   int drop [3] = '{default: 0};
   int hs_cnt [3] = '{default: 0};
   bit known [3] = '{default: 1'b0};
   bit done_e [3] = '{default: 1'b0};
   bit post_rst [3] = '{default: 1'b0};
   logic [7:0] sb [3][$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : gd
      adc_capture_buffer #(.DATA_W(8), .DEPTH(16), .LEN(g == 0 ? 8 : (g == 1 ? 16 : 1))) dut (
         .clk(clk),
         .rst(rst),
         .start(start),
         .adc_data(adc_data),
         .adc_valid(adc_valid),
         .m_data(m_data[g]),
         .m_valid(m_valid[g]),
         .m_ready(m_ready),
         .m_last(m_last[g]),
         .busy(busy[g]),
         .done(done[g]),
         .dropped(dropped[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // compare outputs against the scoreboard, then advance the model with this cycle's inputs
   task automatic check();
      for (int i = 0; i < 3; i++) begin
         bit ev, hs;
         ev = st[i] == 2 && age[i] > 0;
         if (known[i]) begin
            chk($sformatf("u%0d_busy", i), busy[i], st[i] != 0);
            chk($sformatf("u%0d_done", i), done[i], done_e[i]);
            chk($sformatf("u%0d_valid", i), m_valid[i], ev);
            chk($sformatf("u%0d_dropped", i), dropped[i], drop[i]);
            if (ev) begin
               chk($sformatf("u%0d_data", i), m_data[i], sb[i][0]);
               chk($sformatf("u%0d_last", i), m_last[i], sb[i].size() == 1);
            end else chk($sformatf("u%0d_last_idle", i), m_last[i], 0);
            if (post_rst[i]) chk($sformatf("u%0d_rst_data", i), m_data[i], 0);
         end
         hs = ev && m_ready;
         if (rst) begin
            known[i] = 1'b1;
            st[i] = 0;
            sb[i].delete();
            drop[i] = 0;
            done_e[i] = 1'b0;
            post_rst[i] = 1'b1;
         end else if (known[i]) begin
            post_rst[i] = 1'b0;
            done_e[i] = hs && sb[i].size() == 1;
            if (adc_valid && st[i] != 1 && drop[i] < 65535) drop[i]++;
            if (st[i] == 0) begin
               if (start) begin
                  st[i] = 1;
                  sb[i].delete();
               end
            end else if (st[i] == 1) begin
               if (adc_valid) begin
                  sb[i].push_back(adc_data);
                  if (sb[i].size() == lens[i]) begin
                     st[i] = 2;
                     age[i] = 0;
                  end
               end
            end else begin
               age[i]++;
               if (hs) begin
                  void'(sb[i].pop_front());
                  hs_cnt[i]++;
                  if (sb[i].size() == 0) st[i] = 0;
               end
            end
         end
      end
   endtask

   task automatic cyc(input bit s, input bit v, input logic [7:0] d, input bit r);
      start = s;
      adc_valid = v;
      adc_data = v ? d : 8'($urandom);
      m_ready = r;
      @(negedge clk);
      check();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) cyc(0, 0, 8'h00, 0);
      rst = 1'b0;
      repeat (5) cyc(0, 1, 8'hEE, 1);
      cyc(1, 0, 8'h00, 1);
      for (int i = 0; i < 8; i++) cyc(0, 1, 8'(8'h10 + i), 1);
      repeat (3) cyc(0, 1, 8'hDD, 1);
      repeat (10) cyc(0, 0, 8'h00, 1);
      chk("drop8", dropped[0], 8);
      chk("idle_busy", busy[0], 0);
      chk("idle_valid", m_valid[0], 0);
      cyc(1, 0, 8'h00, 1);
      for (int i = 0; i < 16; i++) cyc(0, i % 2 == 0, 8'(8'h20 + i / 2), 1);
      repeat (12) cyc(0, 0, 8'h00, 1);
      cyc(1, 0, 8'h00, 1);
      for (int i = 0; i < 16; i++) cyc(0, 1, 8'(8'h40 + i), 1'($urandom_range(0, 1)));
      repeat (60) cyc(0, 0, 8'h00, 1'($urandom_range(0, 1)));
      repeat (5) cyc(0, 0, 8'h00, 1);
      cyc(1, 0, 8'h00, 1);
      for (int i = 0; i < 8; i++) cyc(0, 1, 8'(8'h60 + i), 1);
      repeat (5) cyc(0, 0, 8'h00, 1);
      chk("mid_valid", m_valid[0], 1);
      chk("mid_data", m_data[0], 8'h64);
      rst = 1'b1;
      cyc(0, 0, 8'h00, 1);
      rst = 1'b0;
      chk("rst_busy", busy[0], 0);
      chk("rst_done", done[0], 0);
      chk("rst_valid", m_valid[0], 0);
      chk("rst_last", m_last[0], 0);
      chk("rst_data", m_data[0], 0);
      chk("rst_dropped", dropped[0], 0);
      cyc(1, 0, 8'h00, 1);
      for (int i = 0; i < 8; i++) cyc(0, 1, 8'(8'h70 + i), 1);
      repeat (12) cyc(0, 0, 8'h00, 1);
      rst = 1'b1;
      cyc(0, 0, 8'h00, 1);
      rst = 1'b0;
      for (int i = 0; i < 80; i++) cyc(1, 1, 8'(i), 1);
      repeat (40) cyc(0, 0, 8'h00, 1);
      chk("u0_streamed", hs_cnt[0] > 40, 1);
      chk("u1_streamed", hs_cnt[1] > 16, 1);
      chk("u2_streamed", hs_cnt[2] > 5, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
